// File: rtl/ifq_param_if.sv
// Fetch-queue bus: I-cache line request/return, decode read port and redirect.
interface ifq_param_if #(
  parameter int XLEN  = 32,
  parameter int WORDS = 4,
  parameter int DEPTH = 4
);
  logic                   o_fetch_req;
  logic [XLEN-1:0]        o_fetch_pc;
  logic [XLEN*WORDS-1:0]  i_line;
  logic                   i_line_valid;
  logic                   o_abort;
  logic                   i_rd_en;
  logic [XLEN-1:0]        o_instr;
  logic [XLEN-1:0]        o_pc;
  logic                   o_valid;
  logic                   i_redirect_valid;
  logic [XLEN-1:0]        i_redirect_pc;
  logic [$clog2(DEPTH):0] o_count;

  modport slave (
    output o_fetch_req, o_fetch_pc, o_abort, o_instr, o_pc, o_valid, o_count,
    input  i_line, i_line_valid, i_rd_en, i_redirect_valid, i_redirect_pc
  );

  modport master (
    input  o_fetch_req, o_fetch_pc, o_abort, o_instr, o_pc, o_valid, o_count,
    output i_line, i_line_valid, i_rd_en, i_redirect_valid, i_redirect_pc
  );
endinterface

// File: rtl/ifq_param.sv
// Instruction fetch queue: circular buffer of I-cache lines with a word cursor,
// one outstanding line request, empty-queue bypass and redirect flush.
module ifq_param #(
  parameter int              XLEN     = 32,
  parameter int              WORDS    = 4,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  ifq_param_if.slave  bus
);
  localparam int              AW         = $clog2(DEPTH);
  localparam int              WB         = $clog2(WORDS);
  localparam int              LB         = WB + 2;
  localparam logic [AW:0]     FULL       = (AW+1)'(DEPTH);
  localparam logic [XLEN-1:0] LINE_BYTES = XLEN'(WORDS*4);
  localparam logic [XLEN-1:0] INSTR_BYTES = XLEN'(4);

  typedef logic [WORDS-1:0][XLEN-1:0] line_t;

  line_t           mem [DEPTH];
  line_t           in_line;
  line_t           head;
  logic [AW:0]     wptr, rptr, count;
  logic            pending;
  logic [WB-1:0]   woff;
  logic [XLEN-1:0] pc, fetch_pc;
  logic            empty, fetch_req, accept, valid, consume, pop;
  logic            unused_rpc;

  assign in_line = bus.i_line;
  assign head    = mem[rptr[AW-1:0]];

  // Pointers carry one extra wrap bit so full and empty stay distinct.
  assign count     = wptr - rptr;
  assign empty     = (count == '0);
  assign fetch_req = i_rst_n & ~pending & (count < FULL) & ~bus.i_redirect_valid;
  assign accept    = i_rst_n & pending & bus.i_line_valid & ~bus.i_redirect_valid;
  assign valid     = i_rst_n & (~empty | accept);
  assign consume   = valid & bus.i_rd_en & ~bus.i_redirect_valid;
  assign pop       = consume & (woff == WB'(WORDS-1));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      pending  <= 1'b0;
      pc       <= RESET_PC;
      woff     <= RESET_PC[LB-1:2];
      fetch_pc <= {RESET_PC[XLEN-1:LB], LB'(0)};
    end else if (bus.i_redirect_valid) begin
      rptr     <= wptr;
      pending  <= 1'b0;
      pc       <= bus.i_redirect_pc;
      woff     <= bus.i_redirect_pc[LB-1:2];
      fetch_pc <= {bus.i_redirect_pc[XLEN-1:LB], LB'(0)};
    end else begin
      if (fetch_req)             pending <= 1'b1;
      else if (bus.i_line_valid) pending <= 1'b0;
      if (accept) begin
        wptr     <= wptr + (AW+1)'(1);
        fetch_pc <= fetch_pc + LINE_BYTES;
      end
      if (consume) begin
        pc   <= pc + INSTR_BYTES;
        woff <= woff + WB'(1);
      end
      // A bypassed line that is popped in the same edge is written and
      // released together, leaving the count unchanged.
      if (pop) rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (accept) mem[wptr[AW-1:0]] <= in_line;
  end

  assign bus.o_fetch_req = fetch_req;
  assign bus.o_fetch_pc  = fetch_pc;
  assign bus.o_abort     = i_rst_n & bus.i_redirect_valid & pending;
  assign bus.o_valid     = valid;
  assign bus.o_instr     = empty ? in_line[woff] : head[woff];
  assign bus.o_pc        = pc;
  assign bus.o_count     = count;

  assign unused_rpc = ^bus.i_redirect_pc[1:0];
endmodule

// File: tb/tb_ifq_param.sv
// Fetch-queue bench: directed scenarios plus random traffic, checked every
// cycle against a word-level queue model of the fetch stream.
module tb_ifq_param;
  localparam int          XLEN     = 32;
  localparam int          WORDS    = 4;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ifq_param_if #(.XLEN(XLEN), .WORDS(WORDS), .DEPTH(DEPTH)) bus ();

  ifq_param #(.XLEN(XLEN), .WORDS(WORDS), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  // Model: one entry per presentable instruction, tagged with its line number.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    int          tag;
  } ent_t;

  ent_t        mq[$];
  logic        m_pend = 1'b0;
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_fpc = 32'h0;
  int          m_start = 0;
  int          m_tag = 0;
  bit          seen_rst = 1'b0;

  int          nvec = 0;
  int          nerr = 0;

  bit          req_fired = 1'b0;
  logic [31:0] req_pc = 32'h0;
  logic [31:0] req_log[$];
  bit          log_en = 1'b0;

  int          cnt = 0;
  int          lat_fix = 2;
  bit          stray_en = 1'b0;
  bit          rand_data = 1'b0;
  logic [31:0] line_pc = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pat(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [127:0] mk_line(input logic [31:0] base);
    logic [127:0] l;
    l = '0;
    for (int k = 0; k < WORDS; k++)
      l[32*k +: 32] = rand_data ? 32'($urandom) : pat(base + 32'(4*k));
    return l;
  endfunction

  // Advance one cycle and play the I-cache: a request seen last cycle
  // returns its line after the configured latency.
  task automatic tick();
    @(posedge clk);
    #1;
    bus.i_line_valid = 1'b0;
    if (req_fired) begin
      cnt     = (lat_fix > 0) ? lat_fix : int'($urandom_range(1, 3));
      line_pc = req_pc;
    end
    if (cnt == 1) begin
      bus.i_line_valid = 1'b1;
      bus.i_line       = mk_line(line_pc);
    end else if (stray_en && $urandom_range(0, 15) == 0) begin
      bus.i_line_valid = 1'b1;
      bus.i_line       = mk_line(32'($urandom));
    end
    if (cnt > 0) cnt--;
  endtask

  always @(negedge clk) begin : cmp
    int          mc;
    bit          e_req, e_abort, acc, e_valid;
    logic [31:0] e_instr;
    ent_t        e;
    mc      = (mq.size() == 0) ? 0 : (mq[$].tag - mq[0].tag + 1);
    e_req   = rst_n && !m_pend && (mc < DEPTH) && !bus.i_redirect_valid;
    e_abort = rst_n && bus.i_redirect_valid && m_pend;
    acc     = rst_n && m_pend && bus.i_line_valid && !bus.i_redirect_valid;
    e_valid = 1'b0;
    e_instr = '0;
    if (rst_n && mq.size() > 0) begin
      e_valid = 1'b1;
      e_instr = mq[0].instr;
    end else if (acc) begin
      e_valid = 1'b1;
      e_instr = bus.i_line[32*m_start +: 32];
    end
    if (seen_rst) begin
      chk("fetch_req", 32'(bus.o_fetch_req), 32'(e_req));
      chk("abort",     32'(bus.o_abort),     32'(e_abort));
      chk("valid",     32'(bus.o_valid),     32'(e_valid));
      chk("count",     32'(bus.o_count),     32'(mc));
      chk("fetch_pc",  bus.o_fetch_pc,       m_fpc);
      chk("pc",        bus.o_pc,             m_pc);
      if (e_valid) chk("instr", bus.o_instr, e_instr);
    end
    req_fired = bus.o_fetch_req;
    req_pc    = bus.o_fetch_pc;
    if (log_en && bus.o_fetch_req) req_log.push_back(bus.o_fetch_pc);

    // Move the model across the coming clock edge.
    if (!rst_n) begin
      mq.delete();
      m_pend   = 1'b0;
      m_pc     = RESET_PC;
      m_start  = int'(RESET_PC[3:2]);
      m_fpc    = RESET_PC & ~32'hF;
      seen_rst = 1'b1;
    end else if (bus.i_redirect_valid) begin
      mq.delete();
      m_pend  = 1'b0;
      m_pc    = bus.i_redirect_pc;
      m_start = int'(bus.i_redirect_pc[3:2]);
      m_fpc   = bus.i_redirect_pc & ~32'hF;
    end else begin
      if (acc) begin
        for (int k = m_start; k < WORDS; k++) begin
          e.pc    = m_fpc + 32'(4*k);
          e.instr = bus.i_line[32*k +: 32];
          e.tag   = m_tag;
          mq.push_back(e);
        end
        m_tag++;
        m_fpc   = m_fpc + 32'd16;
        m_start = 0;
      end
      if (e_req) m_pend = 1'b1;
      else if (bus.i_line_valid) m_pend = 1'b0;
      if (e_valid && bus.i_rd_en) begin
        void'(mq.pop_front());
        m_pc = m_pc + 32'd4;
      end
    end
  end

  initial begin
    int n;
    bus.i_line           = '0;
    bus.i_line_valid     = 1'b0;
    bus.i_rd_en          = 1'b0;
    bus.i_redirect_valid = 1'b0;
    bus.i_redirect_pc    = '0;
    repeat (3) tick();

    // Fill from reset with no consumer: four line requests, then idle.
    log_en = 1'b1;
    rst_n  = 1'b1;
    repeat (24) tick();
    @(negedge clk);
    chk("a_req_total", 32'(req_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < req_log.size(); i++)
      chk("a_fetch_pc", req_log[i], 32'(i*16));
    chk("a_count_full", 32'(bus.o_count), 32'd4);
    chk("a_req_idle", 32'(bus.o_fetch_req), 32'd0);
    log_en = 1'b0;

    // Drain sixteen instructions from a full queue.
    for (int i = 0; i < 16; i++) begin
      tick();
      bus.i_rd_en = 1'b1;
      @(negedge clk);
      chk("b_pc", bus.o_pc, 32'(i*4));
      chk("b_instr", bus.o_instr, pat(32'(i*4)));
      chk("b_valid", 32'(bus.o_valid), 32'd1);
      if (i == 4) begin
        chk("b_count_after_pop", 32'(bus.o_count), 32'd3);
        chk("b_req_after_pop", 32'(bus.o_fetch_req), 32'd1);
      end
    end
    tick();
    bus.i_rd_en = 1'b0;
    repeat (10) tick();

    // Empty queue: first line bypasses straight to decode.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.i_rd_en = 1'b1;
    n = 0;
    while (!bus.i_line_valid && n < 10) begin
      tick();
      n++;
    end
    chk("c_line_seen", 32'(n < 10), 32'd1);
    @(negedge clk);
    chk("c_bypass_instr", bus.o_instr, pat(32'h0));
    chk("c_bypass_pc", bus.o_pc, 32'h0);
    chk("c_bypass_valid", 32'(bus.o_valid), 32'd1);
    tick();
    @(negedge clk);
    chk("c_next_instr", bus.o_instr, pat(32'h4));
    chk("c_next_pc", bus.o_pc, 32'h4);
    chk("c_next_count", 32'(bus.o_count), 32'd1);

    // Redirect while a request is outstanding.
    n = 0;
    do begin
      tick();
      bus.i_rd_en = 1'b0;
      n++;
    end while (!req_fired && n < 20);
    chk("d_pending_seen", 32'(n < 20), 32'd1);
    bus.i_redirect_valid = 1'b1;
    bus.i_redirect_pc    = 32'h108;
    @(negedge clk);
    chk("d_abort", 32'(bus.o_abort), 32'd1);
    tick();
    bus.i_redirect_valid = 1'b0;
    @(negedge clk);
    chk("d_abort_once", 32'(bus.o_abort), 32'd0);
    chk("d_count_flushed", 32'(bus.o_count), 32'd0);
    chk("d_late_line_dropped", 32'(bus.o_valid), 32'd0);
    chk("d_next_req", 32'(bus.o_fetch_req), 32'd1);
    chk("d_next_fetch_pc", bus.o_fetch_pc, 32'h100);
    n = 0;
    do begin
      tick();
      n++;
      @(negedge clk);
    end while (!bus.o_valid && n < 10);
    chk("d_first_pc", bus.o_pc, 32'h108);
    chk("d_first_instr", bus.o_instr, pat(32'h108));

    // Redirect, line return and read in the same cycle.
    n = 0;
    do begin
      tick();
      bus.i_rd_en = 1'b1;
      n++;
    end while (!bus.i_line_valid && n < 20);
    chk("e_line_seen", 32'(n < 20), 32'd1);
    bus.i_redirect_valid = 1'b1;
    bus.i_redirect_pc    = 32'h200;
    tick();
    bus.i_redirect_valid = 1'b0;
    @(negedge clk);
    chk("e_valid_dropped", 32'(bus.o_valid), 32'd0);
    chk("e_pc_target", bus.o_pc, 32'h200);

    // Reset with three lines stored and a request outstanding.
    n = 0;
    do begin
      tick();
      bus.i_rd_en = 1'b0;
      n++;
    end while (!(req_fired && bus.o_count == 3) && n < 40);
    chk("f_setup", 32'(n < 40), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("f_rst_req", 32'(bus.o_fetch_req), 32'd0);
    chk("f_rst_valid", 32'(bus.o_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("f_count", 32'(bus.o_count), 32'd0);
    chk("f_pc", bus.o_pc, 32'h0);
    chk("f_valid", 32'(bus.o_valid), 32'd0);
    chk("f_fetch_pc", bus.o_fetch_pc, 32'h0);

    // Random traffic: variable latency, stray lines, redirects, resets.
    lat_fix   = 0;
    stray_en  = 1'b1;
    rand_data = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      rst_n                = ($urandom_range(0, 199) != 0);
      bus.i_rd_en          = ($urandom_range(0, 9) < 6);
      bus.i_redirect_valid = ($urandom_range(0, 29) == 0);
      bus.i_redirect_pc    = ($urandom_range(0, 7) == 0)
                             ? (32'hFFFF_FFE0 | 32'($urandom_range(0, 7) << 2))
                             : ($urandom & ~32'h3);
    end
    tick();
    rst_n                = 1'b1;
    bus.i_redirect_valid = 1'b0;
    bus.i_rd_en          = 1'b0;
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
